// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add sequencer driving an external full adder; optional ovf output under SERIAL_ADD_OVF_EN
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_out_q, sum_out_d;
    logic             cout_out_q, cout_out_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        sum_sh_d   = sum_sh_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        sum_out_d  = sum_out_q;
        cout_out_d = cout_out_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d      = ovf_q;
`endif
        fa_a   = 1'b0;
        fa_b   = 1'b0;
        fa_cin = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d   = a_in;
                    b_sh_d   = b_in;
                    carry_d  = cin_in;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                fa_a     = a_sh_q[0];
                fa_b     = b_sh_q[0];
                fa_cin   = carry_q;
                busy     = 1'b1;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
                carry_d  = fa_cout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d    = S_DONE;
                    sum_out_d  = {fa_sum, sum_sh_q[WIDTH-1:1]};
                    cout_out_d = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q is the carry into the MSB during the last bit
                    ovf_d      = carry_q ^ fa_cout;
`endif
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            sum_sh_q   <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            sum_out_q  <= '0;
            cout_out_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            sum_sh_q   <= sum_sh_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            sum_out_q  <= sum_out_d;
            cout_out_q <= cout_out_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign sum_out  = sum_out_q;
    assign cout_out = cout_out_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - randomized self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin_in = 1'b0;
    logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic         busy, done, cout_out;
    logic [W-1:0] sum_out;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // external full adder
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_sum(fa_sum), .fa_cout(fa_cout),
        .busy(busy), .done(done), .sum_out(sum_out),
`ifdef SERIAL_ADD_OVF_EN
        .ovf(ovf),
`endif
        .cout_out(cout_out)
    );

    // One operation starting from an IDLE negedge. poke_cycle: RUN cycle (1..W) or
    // DONE cycle (W+1) in which a stray start is driven; reset_cycle: RUN cycle to reset in.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input int poke_cycle, input int reset_cycle);
        int  sum_full, ci, mask, sa, sb, ss;
        logic [2:0] exp_fa;
        logic exp_ovf;
        sum_full = int'(a) + int'(b) + int'(c);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ss = sa + sb + int'(c);
        exp_ovf = (ss > 127) || (ss < -128);
        checks++;
        if ({busy, done, fa_a, fa_b, fa_cin} !== 5'b0) begin
            errors++;
            $display("FAIL idle_outputs: got busy/done/fa=%b need 00000", {busy, done, fa_a, fa_b, fa_cin});
        end
        start = 1'b1; a_in = a; b_in = b; cin_in = c;
        @(negedge clk);
        for (int k = 1; k <= W; k++) begin
            if (reset_cycle == k) begin
                reset = 1'b1;
                start = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                checks++;
                if ({busy, done, cout_out} !== 3'b0 || sum_out !== '0) begin
                    errors++;
                    $display("FAIL reset_abort: got busy=%b done=%b sum=%h cout=%b need 0 0 00 0", busy, done, sum_out, cout_out);
                end
                for (int j = 0; j < W + 3; j++) begin
                    @(negedge clk);
                    checks++;
                    if (done !== 1'b0 || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL reset_no_done: got done=%b busy=%b need 0 0 at idle cycle %0d", done, busy, j);
                    end
                end
                return;
            end
            mask = (1 << (k - 1)) - 1;
            ci = ((int'(a) & mask) + (int'(b) & mask) + int'(c)) >> (k - 1);
            exp_fa = {a[k-1], b[k-1], ci[0]};
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || {fa_a, fa_b, fa_cin} !== exp_fa) begin
                errors++;
                $display("FAIL run_cycle%0d: got busy=%b done=%b fa=%b need busy=1 done=0 fa=%b", k, busy, done, {fa_a, fa_b, fa_cin}, exp_fa);
            end
            start = (poke_cycle == k);
            a_in = W'($urandom); b_in = W'($urandom); cin_in = 1'($urandom);
            @(negedge clk);
        end
        start = (poke_cycle == W + 1);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || {cout_out, sum_out} !== (W+1)'(sum_full)) begin
            errors++;
            $display("FAIL result: got done=%b busy=%b cout=%b sum=%h need done=1 busy=0 %h", done, busy, cout_out, sum_out, (W+1)'(sum_full));
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (ovf !== exp_ovf) begin
            errors++;
            $display("FAIL ovf: got %b need %b for %h+%h+%b", ovf, exp_ovf, a, b, c);
        end
`endif
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {cout_out, sum_out} !== (W+1)'(sum_full)) begin
            errors++;
            $display("FAIL after_done: got done=%b busy=%b result=%h need 0 0 %h", done, busy, {cout_out, sum_out}, (W+1)'(sum_full));
        end
        if (poke_cycle == W + 1) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL start_in_done: got busy=%b need 0", busy);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, cout_out, fa_a, fa_b, fa_cin} !== 6'b0 || sum_out !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b fa=%b need all 0", busy, done, sum_out, cout_out, {fa_a, fa_b, fa_cin});
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        run_op(8'h00, 8'h00, 1'b0, 0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 0);
        run_op(8'h5A, 8'h33, 1'b1, 0, 0);
        run_op(8'hAA, 8'h55, 1'b1, 0, 0);
    endtask

    task automatic test_ignored_start();
        a_in = 8'hF0; b_in = 8'hF0;
        run_op(8'h0F, 8'h01, 1'b0, 3, 0);
        run_op(8'h21, 8'h43, 1'b0, W + 1, 0);
    endtask

    task automatic test_reset_mid_run();
        run_op(8'hFF, 8'hFF, 1'b1, 0, 4);
        run_op(8'h01, 8'h02, 1'b0, 0, 0);
        start = 1'b1; reset = 1'b1; a_in = 8'h11; b_in = 8'h22;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || sum_out !== '0) begin
            errors++;
            $display("FAIL reset_beats_start: got busy=%b sum=%h need 0 00", busy, sum_out);
        end
    endtask

    task automatic test_overflow();
        run_op(8'h7F, 8'h01, 1'b0, 0, 0);
        run_op(8'h80, 8'h80, 1'b0, 0, 0);
        run_op(8'h10, 8'h20, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back_random();
        for (int n = 0; n < 24; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, W + 1)), 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_reset_mid_run();
        test_overflow();
        test_back_to_back_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
